fifo_stream_reader: RTL and testbench

Read-side controller for `fifo_sync`. It drains the FIFO through its `rd_en`/`data_out`/`empty` port and re-presents the words as a valid/ready stream with no bubbles. It sits between `fifo_sync` and any downstream consumer. It absorbs the FIFO's one-cycle read latency in a 2-entry output buffer, so the consumer can apply backpressure freely without data loss.

---
 rtl/fifo_pkg.sv | 6 +
 rtl/fifo_rd_skid.sv | 45 ++++
 rtl/fifo_stream_reader.sv | 81 ++++++++
 tb/tb_fifo_stream_reader.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and types for the fifo_sync read-side blocks
package fifo_pkg;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int STATS_W        = 32;
  typedef logic [1:0] occ_t;
endpackage

// File: rtl/fifo_rd_skid.sv
// rtl/fifo_rd_skid.sv - two-slot in-order output buffer with head pointer and occupancy
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [1:0]            o_occ,
  output logic [DATA_WIDTH-1:0] o_head_data
);

  logic [DATA_WIDTH-1:0] r_slot [2];
  logic                  r_head;
  occ_t                  r_occ;
  logic                  w_tail;

  // Tail sits occ slots past the head; with occ==1 and push+pop together the
  // new word lands exactly where the advanced head will point.
  assign w_tail = r_head ^ r_occ[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot[0] <= '0;
      r_slot[1] <= '0;
      r_head    <= 1'b0;
      r_occ     <= '0;
    end else begin
      if (i_push) begin
        r_slot[w_tail] <= i_push_data;
      end
      if (i_pop) begin
        r_head <= ~r_head;
      end
      r_occ <= r_occ + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_occ       = r_occ;
  assign o_head_data = r_slot[r_head];

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - drains fifo_sync into a bubble-free valid/ready stream
// Optional FIFO_RD_STATS_EN adds words_out and stall_cycles counters.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  busy
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [STATS_W-1:0]    words_out,
  output logic [STATS_W-1:0]    stall_cycles
`endif
);

  logic       r_inflight;
  logic [1:0] w_occ;
  logic       w_pop;
  logic [2:0] w_level;

  assign w_pop   = m_valid && m_ready;
  // Words already committed to the buffer after this edge; a pop only happens
  // with occ >= 1, so this never underflows.
  assign w_level = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

  assign fifo_rd_en = en && !fifo_empty && (w_level < 3'd2);
  assign m_valid    = (w_occ != 2'd0);
  assign busy       = m_valid || r_inflight;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= fifo_rd_en;
    end
  end

  fifo_rd_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (r_inflight),
    .i_push_data(fifo_data_out),
    .i_pop      (w_pop),
    .o_occ      (w_occ),
    .o_head_data(m_data)
  );

`ifdef FIFO_RD_STATS_EN
  logic [STATS_W-1:0] r_words_out;
  logic [STATS_W-1:0] r_stall_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_words_out    <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (w_pop) begin
        r_words_out <= r_words_out + 1'b1;
      end
      if (m_valid && !m_ready) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
    end
  end

  assign words_out    = r_words_out;
  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - self-checking bench for fifo_stream_reader
module tb_fifo_stream_reader;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          m_ready = 1'b0;
  logic          push = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          busy;
  logic [DW-1:0] fifo_data_out;
  logic [DW-1:0] m_data;
`ifdef FIFO_RD_STATS_EN
  logic [31:0]   words_out;
  logic [31:0]   stall_cycles;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .fifo_empty   (fifo_empty),
    .fifo_data_out(fifo_data_out),
    .fifo_rd_en   (fifo_rd_en),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_ready      (m_ready),
    .busy         (busy)
`ifdef FIFO_RD_STATS_EN
    ,
    .words_out    (words_out),
    .stall_cycles (stall_cycles)
`endif
  );

  // Stand-in for fifo_sync: registered data_out, one cycle after rd_en.
  logic [DW-1:0] mem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= 0;
      rd_ptr        <= 0;
      fifo_data_out <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr % 64] <= push_data;
        wr_ptr           <= wr_ptr + 1;
      end
      if (fifo_rd_en) begin
        fifo_data_out <= mem[rd_ptr % 64];
        rd_ptr        <= rd_ptr + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Reference: every word read from the FIFO becomes visible two cycles later
  // and leaves in read order; at most two words may be owed to the consumer.
  logic [DW-1:0] q_data [$];
  int            q_avail [$];
  int            cyc = 0;
  logic [DW-1:0] out_log [$];
  int            out_cyc [$];
  int            rd_log [$];

  always @(negedge clk) begin : model
    logic exp_valid;
    logic exp_pop;
    logic exp_rd;
    if (!rst_n) begin
      check("rst_m_valid", {31'd0, m_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
      q_data.delete();
      q_avail.delete();
    end else begin
      exp_valid = (q_data.size() > 0) && (q_avail[0] <= cyc);
      exp_pop   = exp_valid && m_ready;
      exp_rd    = en && !fifo_empty && ((q_data.size() - int'(exp_pop)) < 2);
      check("m_valid", {31'd0, m_valid}, {31'd0, exp_valid});
      if (exp_valid) check("m_data", m_data, q_data[0]);
      check("fifo_rd_en", {31'd0, fifo_rd_en}, {31'd0, exp_rd});
      check("busy", {31'd0, busy}, {31'd0, q_data.size() != 0});
      if (m_valid && m_ready) begin
        out_log.push_back(m_data);
        out_cyc.push_back(cyc);
      end
      if (exp_pop) begin
        void'(q_data.pop_front());
        void'(q_avail.pop_front());
      end
      if (fifo_rd_en) begin
        rd_log.push_back(cyc);
        q_data.push_back(mem[rd_ptr % 64]);
        q_avail.push_back(cyc + 2);
      end
      cyc++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_words(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      push      = 1'b1;
      push_data = DW'(base + i);
      step(1);
    end
    push = 1'b0;
  endtask

  task automatic clear_logs();
    out_log.delete();
    out_cyc.delete();
    rd_log.delete();
  endtask

  initial begin
    step(2);
    check("reset_m_valid", {31'd0, m_valid}, 32'd0);
    check("reset_m_data", m_data, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    rst_n = 1'b1;
    step(1);

    // 1..8 at full rate
    push_words(1, 8);
    clear_logs();
    en = 1'b1;
    m_ready = 1'b1;
    step(14);
    check("t1_reads", rd_log.size(), 32'd8);
    check("t1_count", out_log.size(), 32'd8);
    for (int i = 0; i < out_log.size() && i < 8; i++) begin
      check("t1_data", out_log[i], 32'(i + 1));
      if (rd_log.size() > 0) check("t1_latency", 32'(out_cyc[i] - rd_log[0]), 32'(i + 2));
    end
    check("t1_rd_idle", {31'd0, fifo_rd_en}, 32'd0);
    check("t1_valid_idle", {31'd0, m_valid}, 32'd0);

    // backpressure
    en = 1'b0;
    push_words(11, 5);
    clear_logs();
    m_ready = 1'b0;
    en = 1'b1;
    step(10);
    check("t2_reads", rd_log.size(), 32'd2);
    check("t2_head", m_data, 32'd11);
    check("t2_valid", {31'd0, m_valid}, 32'd1);
    check("t2_fifo_left", 32'(wr_ptr - rd_ptr), 32'd3);
    m_ready = 1'b1;
    step(10);
    check("t2_count", out_log.size(), 32'd5);
    for (int i = 0; i < out_log.size() && i < 5; i++) check("t2_data", out_log[i], 32'(11 + i));

    // toggling ready while streaming 100..131
    clear_logs();
    m_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      push      = 1'b1;
      push_data = DW'(100 + i);
      m_ready   = ~m_ready;
      step(1);
    end
    push = 1'b0;
    for (int i = 0; i < 40; i++) begin
      m_ready = ~m_ready;
      step(1);
    end
    check("t3_count", out_log.size(), 32'd32);
    for (int i = 0; i < out_log.size() && i < 32; i++) check("t3_data", out_log[i], 32'(100 + i));

    // en dropped after the first read
    en = 1'b0;
    push_words(41, 4);
    clear_logs();
    m_ready = 1'b1;
    en = 1'b1;
    step(1);
    en = 1'b0;
    step(8);
    check("t4_reads", rd_log.size(), 32'd1);
    check("t4_count", out_log.size(), 32'd1);
    if (out_log.size() > 0) check("t4_data", out_log[0], 32'd41);
    check("t4_fifo_left", 32'(wr_ptr - rd_ptr), 32'd3);
    en = 1'b1;
    step(8);
    check("t4_drain_count", out_log.size(), 32'd4);
    if (out_log.size() == 4) check("t4_drain_last", out_log[3], 32'd44);

    // reset with two words buffered
    en = 1'b0;
    push_words(51, 4);
    m_ready = 1'b0;
    en = 1'b1;
    step(5);
    check("t5_pre_valid", {31'd0, m_valid}, 32'd1);
    check("t5_pre_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", {31'd0, m_valid}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_data", m_data, 32'd0);
    step(1);
    rst_n = 1'b1;
    en = 1'b0;
    push_words(77, 1);
    clear_logs();
    en = 1'b1;
    m_ready = 1'b1;
    step(6);
    check("t5_count", out_log.size(), 32'd1);
    if (out_log.size() > 0) check("t5_data", out_log[0], 32'd77);

`ifdef FIFO_RD_STATS_EN
    begin
      int k;
      en = 1'b0;
      m_ready = 1'b0;
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      check("t6_words_reset", words_out, 32'd0);
      check("t6_stall_reset", stall_cycles, 32'd0);
      push_words(61, 6);
      en = 1'b1;
      k = 0;
      while (!m_valid && k < 10) begin
        step(1);
        k++;
      end
      check("t6_valid_wait", {31'd0, m_valid}, 32'd1);
      step(4);
      m_ready = 1'b1;
      step(12);
      check("t6_words_out", words_out, 32'd6);
      check("t6_stall_cycles", stall_cycles, 32'd4);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
